// File: rtl/multi_cycle_control_pkg.sv
// Shared definitions for the multi-cycle MIPS controller.
// Holds the opcode constants, the datapath select encodings, the state
// enumeration and a helper that identifies instruction-retire events.
package multi_cycle_control_pkg;

    // Opcodes (IR[31:26]) understood by the controller
    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_J     = 6'd2;

    // aluOp encodings consumed by the downstream funct-level ALU control
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // aluSrcB encodings
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // pcSource encodings
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_INIT     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_MEM_ADR  = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WB   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_RTYPE_EX = 4'd7,
        ST_RTYPE_WB = 4'd8,
        ST_BEQ_EX   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_TRAP     = 4'd11
    } state_t;

    // An instruction retires on the edge leaving its final state; a store
    // only finishes once memory has accepted the write.
    function automatic logic retire_event(input state_t st, input logic ready);
        logic hit;
        case (st)
            ST_MEM_WB, ST_RTYPE_WB, ST_BEQ_EX, ST_JUMP: hit = 1'b1;
            ST_MEM_WR:                                  hit = ready;
            default:                                    hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS main controller.
// Sequences the shared datapath (single memory, single ALU, IR/MDR/A/B/ALUOut)
// for R-type, lw, sw, beq and j. Stalls on memReady in FETCH, MEM_RD and
// MEM_WR, traps on unsupported opcodes and counts retired instructions.
// Ports:
//   clk, rstN            clock, asynchronous active-low reset
//   opCode[5:0]          IR[31:26], valid from DECODE onward
//   memReady             memory finished the current access this cycle
//   pcWrite..pcSource    datapath write enables and mux selects (Moore)
//   illegalOp            sticky trap flag, cleared only by reset
//   instrCount[CNT_W-1:0] retired-instruction counter, wraps
//   state[3:0]           current state encoding for debug
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic [5:0]       opCode,
    input  logic             memReady,
    output logic             pcWrite,
    output logic             pcWriteCond,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic             memToReg,
    output logic             regDst,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [1:0]       aluOp,
    output logic [1:0]       pcSource,
    output logic             illegalOp,
    output logic [CNT_W-1:0] instrCount,
    output logic [3:0]       state
);

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] count_r;
    logic             illegal_r;
    logic             retire_s;

    // State register
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state selection
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_INIT: next_state_s = ST_FETCH;
            ST_FETCH: begin
                if (memReady) begin
                    next_state_s = ST_DECODE;
                end else begin
                    next_state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                case (opCode)
                    OP_RTYPE:     next_state_s = ST_RTYPE_EX;
                    OP_LW, OP_SW: next_state_s = ST_MEM_ADR;
                    OP_BEQ:       next_state_s = ST_BEQ_EX;
                    OP_J:         next_state_s = ST_JUMP;
                    default:      next_state_s = ST_TRAP;
                endcase
            end
            // opCode is stable from DECODE, so anything other than lw/sw
            // here means IR was corrupted; treat it as an illegal opcode.
            ST_MEM_ADR: begin
                case (opCode)
                    OP_LW:   next_state_s = ST_MEM_RD;
                    OP_SW:   next_state_s = ST_MEM_WR;
                    default: next_state_s = ST_TRAP;
                endcase
            end
            ST_MEM_RD: begin
                if (memReady) begin
                    next_state_s = ST_MEM_WB;
                end else begin
                    next_state_s = ST_MEM_RD;
                end
            end
            ST_MEM_WB: next_state_s = ST_FETCH;
            ST_MEM_WR: begin
                if (memReady) begin
                    next_state_s = ST_FETCH;
                end else begin
                    next_state_s = ST_MEM_WR;
                end
            end
            ST_RTYPE_EX: next_state_s = ST_RTYPE_WB;
            ST_RTYPE_WB: next_state_s = ST_FETCH;
            ST_BEQ_EX:   next_state_s = ST_FETCH;
            ST_JUMP:     next_state_s = ST_FETCH;
            ST_TRAP:     next_state_s = ST_TRAP;
            // Unused encodings are unreachable; park in TRAP so a
            // corrupted state register is flagged rather than executed.
            default:     next_state_s = ST_TRAP;
        endcase
    end

    // Moore output decode; FETCH gates its IR/PC loads with memReady
    always_comb begin
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = SRCB_B;
        aluOp       = ALU_ADD;
        pcSource    = PCSRC_ALU;
        case (state_r)
            ST_FETCH: begin
                memRead = 1'b1;
                aluSrcB = SRCB_FOUR;
                irWrite = memReady;
                pcWrite = memReady;
            end
            ST_DECODE: begin
                aluSrcB = SRCB_IMM_SH2;
            end
            ST_MEM_ADR: begin
                aluSrcA = 1'b1;
                aluSrcB = SRCB_IMM;
            end
            ST_MEM_RD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            ST_MEM_WB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            ST_MEM_WR: begin
                memWrite = 1'b1;
                iorD     = 1'b1;
            end
            ST_RTYPE_EX: begin
                aluSrcA = 1'b1;
                aluOp   = ALU_FUNCT;
            end
            ST_RTYPE_WB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            ST_BEQ_EX: begin
                aluSrcA     = 1'b1;
                aluOp       = ALU_SUB;
                pcWriteCond = 1'b1;
                pcSource    = PCSRC_ALUOUT;
            end
            ST_JUMP: begin
                pcWrite  = 1'b1;
                pcSource = PCSRC_JUMP;
            end
            default: begin
                pcWrite = 1'b0;
            end
        endcase
    end

    assign retire_s = retire_event(state_r, memReady);

    // Retired-instruction counter, wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_r <= {CNT_W{1'b0}};
        end else if (retire_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    // Sticky trap flag, set on the edge that enters TRAP so it is high
    // for the whole time the controller sits in TRAP
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            illegal_r <= 1'b0;
        end else if (next_state_s == ST_TRAP) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegalOp  = illegal_r;
    assign instrCount = count_r;
    assign state      = state_r;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Self-checking bench for multi_cycle_control. Each instruction scenario
// pushes its expected per-cycle state/control trace into a scoreboard queue;
// the drain task replays the memReady stimulus and compares cycle by cycle.
// A second instance with a 4-bit counter exercises counter wrap-around.
module tb_multi_cycle_control;
    import multi_cycle_control_pkg::*;

    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic [5:0]  opCode = 6'd0;
    logic        memReady = 1'b0;

    logic        pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic        memToReg, regDst, regWrite, aluSrcA, illegalOp;
    logic [1:0]  aluSrcB, aluOp, pcSource;
    logic [15:0] instrCount;
    logic [3:0]  state;

    logic        w_pcWrite, w_pcWriteCond, w_iorD, w_memRead, w_memWrite, w_irWrite;
    logic        w_memToReg, w_regDst, w_regWrite, w_aluSrcA, w_illegalOp;
    logic [1:0]  w_aluSrcB, w_aluOp, w_pcSource;
    logic [3:0]  w_instrCount;
    logic [3:0]  w_state;

    logic [16:0] act_ctrl;

    typedef struct packed {
        logic        ready;
        logic [3:0]  st;
        logic [16:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_cnt = 0;

    always #5 clk = ~clk;

    multi_cycle_control #(.CNT_W(16)) dut (
        .clk(clk), .rstN(rstN), .opCode(opCode), .memReady(memReady),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .illegalOp(illegalOp),
        .instrCount(instrCount), .state(state)
    );

    multi_cycle_control #(.CNT_W(4)) dut_w (
        .clk(clk), .rstN(rstN), .opCode(opCode), .memReady(memReady),
        .pcWrite(w_pcWrite), .pcWriteCond(w_pcWriteCond), .iorD(w_iorD),
        .memRead(w_memRead), .memWrite(w_memWrite), .irWrite(w_irWrite),
        .memToReg(w_memToReg), .regDst(w_regDst), .regWrite(w_regWrite),
        .aluSrcA(w_aluSrcA), .aluSrcB(w_aluSrcB), .aluOp(w_aluOp),
        .pcSource(w_pcSource), .illegalOp(w_illegalOp),
        .instrCount(w_instrCount), .state(w_state)
    );

    assign act_ctrl = {illegalOp, pcWrite, pcWriteCond, iorD, memRead, memWrite,
                       irWrite, memToReg, regDst, regWrite, aluSrcA,
                       aluSrcB, aluOp, pcSource};

    // Expected control vector for a state, taken from the state/output table
    function automatic logic [16:0] exp_ctrl(input state_t s, input logic rdy);
        logic il, pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa;
        logic [1:0] srcb, aop, pcs;
        {il, pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa} = 11'd0;
        srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            ST_FETCH:    begin mr = 1'b1; srcb = 2'b01; irw = rdy; pw = rdy; end
            ST_DECODE:   begin srcb = 2'b11; end
            ST_MEM_ADR:  begin sa = 1'b1; srcb = 2'b10; end
            ST_MEM_RD:   begin mr = 1'b1; iord = 1'b1; end
            ST_MEM_WB:   begin rw = 1'b1; m2r = 1'b1; end
            ST_MEM_WR:   begin mw = 1'b1; iord = 1'b1; end
            ST_RTYPE_EX: begin sa = 1'b1; aop = 2'b10; end
            ST_RTYPE_WB: begin rw = 1'b1; rd = 1'b1; end
            ST_BEQ_EX:   begin sa = 1'b1; aop = 2'b01; pwc = 1'b1; pcs = 2'b01; end
            ST_JUMP:     begin pw = 1'b1; pcs = 2'b10; end
            ST_TRAP:     begin il = 1'b1; end
            default:     begin il = 1'b0; end
        endcase
        return {il, pw, pwc, iord, mr, mw, irw, m2r, rd, rw, sa, srcb, aop, pcs};
    endfunction

    function automatic void push(input state_t s, input logic rdy);
        exp_t e;
        e.ready = rdy;
        e.st    = s;
        e.ctrl  = exp_ctrl(s, rdy);
        sb.push_back(e);
    endfunction

    // Queue the full cycle trace for one instruction. memReady is driven low
    // in states that must ignore it.
    task automatic push_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits);
        opCode = op;
        for (int i = 0; i < fetch_waits; i++) push(ST_FETCH, 1'b0);
        push(ST_FETCH, 1'b1);
        push(ST_DECODE, 1'b0);
        case (op)
            6'd0: begin
                push(ST_RTYPE_EX, 1'b0);
                push(ST_RTYPE_WB, 1'b0);
                exp_cnt++;
            end
            6'd35: begin
                push(ST_MEM_ADR, 1'b0);
                for (int i = 0; i < mem_waits; i++) push(ST_MEM_RD, 1'b0);
                push(ST_MEM_RD, 1'b1);
                push(ST_MEM_WB, 1'b0);
                exp_cnt++;
            end
            6'd43: begin
                push(ST_MEM_ADR, 1'b0);
                for (int i = 0; i < mem_waits; i++) push(ST_MEM_WR, 1'b0);
                push(ST_MEM_WR, 1'b1);
                exp_cnt++;
            end
            6'd4: begin
                push(ST_BEQ_EX, 1'b0);
                exp_cnt++;
            end
            6'd2: begin
                push(ST_JUMP, 1'b0);
                exp_cnt++;
            end
            default: begin
                push(ST_TRAP, 1'b1);
                push(ST_TRAP, 1'b0);
                push(ST_TRAP, 1'b1);
            end
        endcase
    endtask

    // Replay the queued trace: drive memReady just after the edge, compare
    // on the falling edge
    task automatic drain(input string tag);
        exp_t e;
        int   cyc;
        cyc = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            memReady = e.ready;
            @(negedge clk);
            checks++;
            if (state !== e.st)
                $display("FAIL %s cyc%0d state: got %0d expected %0d", tag, cyc, state, e.st);
            if (state !== e.st) errors++;
            checks++;
            if (act_ctrl !== e.ctrl) begin
                $display("FAIL %s cyc%0d ctrl: got %b expected %b", tag, cyc, act_ctrl, e.ctrl);
                errors++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic check_count(input string tag);
        logic [15:0] exp16;
        logic [3:0]  exp4;
        exp16 = exp_cnt[15:0];
        exp4  = exp_cnt[3:0];
        checks++;
        if (instrCount !== exp16) begin
            $display("FAIL %s instrCount: got %0d expected %0d", tag, instrCount, exp16);
            errors++;
        end
        checks++;
        if (w_instrCount !== exp4) begin
            $display("FAIL %s narrow instrCount: got %0d expected %0d", tag, w_instrCount, exp4);
            errors++;
        end
    endtask

    task automatic check_reset_state(input string tag);
        checks++;
        if (state !== 4'd0 || w_state !== 4'd0) begin
            $display("FAIL %s state: got %0d/%0d expected 0", tag, state, w_state);
            errors++;
        end
        checks++;
        if (act_ctrl !== 17'd0) begin
            $display("FAIL %s outputs: got %b expected all zero", tag, act_ctrl);
            errors++;
        end
        check_count(tag);
    endtask

    task automatic test_reset_rtype();
        rstN = 1'b0;
        memReady = 1'b0;
        opCode = 6'd0;
        repeat (2) @(posedge clk);
        #1;
        exp_cnt = 0;
        check_reset_state("reset");
        rstN = 1'b1;
        push(ST_INIT, 1'b1);
        push_instr(6'd0, 0, 0);
        drain("rtype");
        check_count("rtype");
    endtask

    task automatic test_lw_wait();
        push_instr(6'd35, 0, 2);
        drain("lw_wait");
        check_count("lw_wait");
    endtask

    task automatic test_sw();
        push_instr(6'd43, 0, 0);
        drain("sw");
        check_count("sw");
    endtask

    task automatic test_beq_jump();
        push_instr(6'd4, 0, 0);
        drain("beq");
        check_count("beq");
        push_instr(6'd2, 0, 0);
        drain("jump");
        check_count("jump");
    endtask

    task automatic test_fetch_stall();
        push_instr(6'd0, 3, 0);
        drain("fetch_stall");
        check_count("fetch_stall");
    endtask

    // Back-to-back jumps carry the 4-bit counter through 15 -> 0
    task automatic test_back_to_back_wrap();
        while (exp_cnt < 17) begin
            push_instr(6'd2, 0, 0);
            drain("b2b_jump");
            check_count("wrap");
        end
    endtask

    task automatic test_trap_reset();
        push_instr(6'd63, 0, 0);
        drain("trap");
        check_count("trap");
        @(posedge clk);
        #3;
        rstN = 1'b0;
        #1;
        exp_cnt = 0;
        check_reset_state("async_reset");
        checks++;
        if (illegalOp !== 1'b0 || w_illegalOp !== 1'b0) begin
            $display("FAIL async_reset illegalOp: got %b/%b expected 0", illegalOp, w_illegalOp);
            errors++;
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        push(ST_INIT, 1'b0);
        push_instr(6'd2, 0, 0);
        drain("post_reset");
        check_count("post_reset");
    endtask

    initial begin
        test_reset_rtype();
        test_lw_wait();
        test_sw();
        test_beq_jump();
        test_fetch_stall();
        test_back_to_back_wrap();
        test_trap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_cycle_control.md
Name: multi_cycle_control

Overview:
Multi-cycle MIPS controller that sequences the shared datapath (single memory, single ALU, IR/MDR/A/B/ALUOut registers) over several clock cycles per instruction. It supports R-type, lw, sw, beq and j. It stalls on a memory ready handshake, traps on unsupported opcodes, and counts retired instructions. It sits beside the datapath top level and drives every datapath mux select and write enable.

Parameters:
CNT_W  16  width of retired-instruction counter

Ports:
clk  input  1  system clock, rising edge
rstN  input  1  asynchronous active-low reset
opCode  input  6  IR[31:26]; valid from DECODE onward
memReady  input  1  memory completed current access this cycle
pcWrite  output  1  unconditional PC load
pcWriteCond  output  1  PC load if ALU zero
iorD  output  1  memory address select: 0=PC, 1=ALUOut
memRead  output  1  memory read strobe
memWrite  output  1  memory write strobe
irWrite  output  1  IR load
memToReg  output  1  write-back data: 0=ALUOut, 1=MDR
regDst  output  1  dest reg: 0=rt, 1=rd
regWrite  output  1  register file write
aluSrcA  output  1  0=PC, 1=A
aluSrcB  output  2  00=B, 01=const 4, 10=signext imm, 11=signext imm<<2
aluOp  output  2  00=add, 01=sub, 10=funct-decoded
pcSource  output  2  00=ALU result, 01=ALUOut, 10=jump target
illegalOp  output  1  sticky trap flag
instrCount  output  CNT_W  retired instructions, wraps
state  output  4  current state encoding, for debug

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-low, on rstN. Reset takes effect immediately, including mid-instruction: state=INIT, instrCount=0, illegalOp=0, and all outputs 0.
- The state register is the only sequential element besides instrCount and illegalOp. Outputs are Moore, combinational from state. The exceptions are irWrite and pcWrite in FETCH, which are additionally ANDed with memReady.
- Unlisted outputs are 0 in each state.
- States and outputs:
  - INIT: all 0. Goes to FETCH on the next edge.
  - FETCH: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=00, pcSource=00, irWrite=pcWrite=memReady. Stays while memReady=0; goes to DECODE when memReady=1.
  - DECODE: aluSrcA=0, aluSrcB=11, aluOp=00 (branch target precompute). Next state by opCode:
    - 0 -> RTYPE_EX
    - 35 or 43 -> MEM_ADR
    - 4 -> BEQ_EX
    - 2 -> JUMP
    - any other -> TRAP
  - MEM_ADR: aluSrcA=1, aluSrcB=10, aluOp=00. Goes to MEM_RD if opCode=35, MEM_WR if opCode=43.
  - MEM_RD: memRead=1, iorD=1. Waits for memReady, then goes to MEM_WB.
  - MEM_WB: regWrite=1, memToReg=1, regDst=0. Goes to FETCH.
  - MEM_WR: memWrite=1, iorD=1. Waits for memReady, then goes to FETCH.
  - RTYPE_EX: aluSrcA=1, aluSrcB=00, aluOp=10. Goes to RTYPE_WB.
  - RTYPE_WB: regWrite=1, regDst=1, memToReg=0. Goes to FETCH.
  - BEQ_EX: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. Goes to FETCH.
  - JUMP: pcWrite=1, pcSource=10. Goes to FETCH.
  - TRAP: illegalOp=1, no strobes. Holds until reset.
- Latency with zero wait states: R=4, lw=5, sw=4, beq=3, j=3 cycles. Each memReady=0 cycle in FETCH, MEM_RD or MEM_WR adds one cycle.
- memReady is ignored in all states other than FETCH, MEM_RD and MEM_WR.
- Retire: instrCount increments by 1 on the edge leaving MEM_WB, RTYPE_WB, BEQ_EX or JUMP, and on the edge where MEM_WR sees memReady=1. It wraps from 2^CNT_W-1 to 0. TRAP does not count.
- memRead and memWrite are never asserted in the same cycle.
- regWrite is never asserted outside MEM_WB and RTYPE_WB.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE=0, OP_LW=35, OP_SW=43, OP_BEQ=4, OP_J=2)
  - aluOp encodings (ADD=00, SUB=01, FUNCT=10)
  - aluSrcB encodings
  - pcSource encodings
  - state enum (4 bits)
- Sub-modules: none required. The FSM, output decode and counter fit in one module.
- The existing funct-level ALU control stays downstream and consumes aluOp.

Test Plan:
- Reset then release, memReady=1, opCode=0: states INIT, FETCH, DECODE, RTYPE_EX, RTYPE_WB, FETCH. regWrite=1 and regDst=1 only in RTYPE_WB. instrCount=1.
- opCode=35, memReady low for 2 cycles in MEM_RD: lw takes 7 cycles. memRead=1 and iorD=1 held for 3 cycles. regWrite/memToReg pulse once. instrCount +1.
- opCode=43, memReady=1: 4 cycles. memWrite=1 for exactly 1 cycle. regWrite is never 1. instrCount +1.
- opCode=4, then opCode=2: BEQ_EX shows pcWriteCond=1, pcSource=01. JUMP shows pcWrite=1, pcSource=10. Each takes 3 cycles.
- FETCH with memReady=0 for 3 cycles: irWrite=pcWrite=0 throughout, then both 1 in the memReady cycle.
- opCode=63: TRAP reached after DECODE, illegalOp=1 held. Then assert rstN=0 mid-cycle: outputs 0 immediately. Also preload instrCount to 2^16-1 and retire one instruction: counter wraps to 0.
